// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encoding
// and controller state.
package HighLevelControl;

  localparam int FWD_W = 2;

  typedef enum logic [FWD_W-1:0] {
    FWD_NONE    = 2'd0,
    FWD_COMPUTE = 2'd1,
    FWD_MEM     = 2'd2
  } fwdSrc;

  typedef enum logic {
    LISTEN,
    LOAD_WAIT
  } hazardState;

endpackage

// File: rtl/hazard_ctrl_unit_src_match.sv
// Dependency check for one R-stage source operand against the C and M stage
// destinations; produces the forward select that operand will need in C.
module hazard_src_match
  import HighLevelControl::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_adr_i,
  input  logic [ADDR_W-1:0] rd_adr_c_i,
  input  logic [ADDR_W-1:0] rd_adr_m_i,
  input  logic              reg_write_c_i,
  input  logic              reg_write_m_i,
  input  logic              mem_en_c_i,
  output logic              hit_c_o,
  output logic              hit_m_o,
  output logic              load_hit_o,
  output logic [FWD_W-1:0]  sel_o
);

  fwdSrc sel;

  // Register 0 is hard-wired, so it never carries a dependency.
  assign hit_c_o    = reg_write_c_i && (src_adr_i != '0) && (src_adr_i == rd_adr_c_i);
  assign hit_m_o    = reg_write_m_i && (src_adr_i != '0) && (src_adr_i == rd_adr_m_i);
  assign load_hit_o = hit_c_o && mem_en_c_i;

  always_comb begin
    sel = FWD_NONE;
    if (hit_c_o) begin
      sel = mem_en_c_i ? FWD_MEM : FWD_COMPUTE;
    end else if (hit_m_o) begin
      sel = FWD_MEM;
    end
  end

  assign sel_o = sel;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the R/C/M pipeline: operand forwarding, load-use
// bubbles, taken-branch squash and whole-pipe freeze on data-memory wait.
module hazard_ctrl_unit
  import HighLevelControl::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*ADDR_W-1:0] SrcAdr_R,
  input  logic [ADDR_W-1:0]         RdAdr_C,
  input  logic [ADDR_W-1:0]         RdAdr_M,
  input  logic                      RegWrite_C,
  input  logic                      RegWrite_M,
  input  logic                      MemEn_C,
  input  logic                      BranchTaken_C,
  input  logic                      MemReady_M,
  output logic [NUM_SRC*2-1:0]      FwdSel,
  output logic                      StallPC,
  output logic                      StallIR,
  output logic                      StallRC,
  output logic                      StallCM,
  output logic                      FlushIR,
  output logic                      FlushRC,
  output logic                      FlushCM
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  hazardState           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SRC*2-1:0] fwd_q, fwd_d;

  logic [NUM_SRC-1:0]   hit_c, hit_m, load_hit;
  logic [NUM_SRC*2-1:0] sel_nxt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(.ADDR_W(ADDR_W)) u_match (
      .src_adr_i     (SrcAdr_R[i*ADDR_W +: ADDR_W]),
      .rd_adr_c_i    (RdAdr_C),
      .rd_adr_m_i    (RdAdr_M),
      .reg_write_c_i (RegWrite_C),
      .reg_write_m_i (RegWrite_M),
      .mem_en_c_i    (MemEn_C),
      .hit_c_o       (hit_c[i]),
      .hit_m_o       (hit_m[i]),
      .load_hit_o    (load_hit[i]),
      .sel_o         (sel_nxt[i*2 +: 2])
    );
  end

  // A load hit is always a C hit, and a non-NONE select always comes from a hit.
  a_load_is_c_hit : assert property (@(posedge clk) disable iff (reset)
    (load_hit & ~hit_c) == '0);
  a_sel_from_hit : assert property (@(posedge clk) disable iff (reset)
    (|sel_nxt) == (|(hit_c | hit_m)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LISTEN;
      cnt_q   <= '0;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd_q   <= fwd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fwd_d   = fwd_q;
    StallPC = 1'b0;
    StallIR = 1'b0;
    StallRC = 1'b0;
    StallCM = 1'b0;
    FlushIR = 1'b0;
    FlushRC = 1'b0;
    FlushCM = 1'b0;
    if (!reset) begin
      if (!MemReady_M) begin
        StallPC = 1'b1;
        StallIR = 1'b1;
        StallRC = 1'b1;
        StallCM = 1'b1;
      end else if (state_q == LOAD_WAIT) begin
        // C holds a bubble here, so a branch indication is meaningless.
        StallPC = 1'b1;
        StallIR = 1'b1;
        StallRC = 1'b1;
        FlushCM = 1'b1;
        if (cnt_q == '0) begin
          state_d = LISTEN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (BranchTaken_C) begin
        FlushIR = 1'b1;
        FlushRC = 1'b1;
        fwd_d   = '0;
      end else begin
        fwd_d = sel_nxt;
        if (|load_hit) begin
          state_d = LOAD_WAIT;
          cnt_d   = CNT_W'(LOAD_LAT - 1);
        end
      end
    end
  end

  assign FwdSel = fwd_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed hazard scenarios followed by
// randomized traffic, checked against a bubble-count reference model.
module tb_hazard_ctrl_unit;

  localparam int ADDR_W   = 5;
  localparam int NUM_SRC  = 2;
  localparam int LOAD_LAT = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC*ADDR_W-1:0] SrcAdr_R;
  logic [ADDR_W-1:0]         RdAdr_C, RdAdr_M;
  logic                      RegWrite_C, RegWrite_M, MemEn_C, BranchTaken_C, MemReady_M;
  logic [NUM_SRC*2-1:0]      FwdSel;
  logic StallPC, StallIR, StallRC, StallCM, FlushIR, FlushRC, FlushCM;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .reset(reset), .SrcAdr_R(SrcAdr_R), .RdAdr_C(RdAdr_C), .RdAdr_M(RdAdr_M),
    .RegWrite_C(RegWrite_C), .RegWrite_M(RegWrite_M), .MemEn_C(MemEn_C),
    .BranchTaken_C(BranchTaken_C), .MemReady_M(MemReady_M), .FwdSel(FwdSel),
    .StallPC(StallPC), .StallIR(StallIR), .StallRC(StallRC), .StallCM(StallCM),
    .FlushIR(FlushIR), .FlushRC(FlushRC), .FlushCM(FlushCM)
  );

  // ctl = {StallPC, StallIR, StallRC, StallCM, FlushIR, FlushRC, FlushCM}
  typedef struct packed {
    logic                 chk_fwd;
    logic [NUM_SRC*2-1:0] fwd;
    logic [6:0]           ctl;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: forward selects seen by the instruction now in C, and
  // the number of load-use bubbles still owed.
  logic [1:0] m_fwd [NUM_SRC];
  int         m_left  = 0;
  bit         m_known = 1'b0;

  task automatic step(input bit rst, input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1,
                      input logic [ADDR_W-1:0] rdc, input logic [ADDR_W-1:0] rdm,
                      input bit rwc, input bit rwm, input bit memc, input bit br, input bit mrdy);
    exp_t e;
    logic [ADDR_W-1:0] s [NUM_SRC];
    bit cm, mm, hit;
    s[0] = s0;
    s[1] = s1;
    reset         = rst;
    SrcAdr_R      = {s1, s0};
    RdAdr_C       = rdc;
    RdAdr_M       = rdm;
    RegWrite_C    = rwc;
    RegWrite_M    = rwm;
    MemEn_C       = memc;
    BranchTaken_C = br;
    MemReady_M    = mrdy;

    e.chk_fwd = m_known;
    e.fwd     = '0;
    for (int i = 0; i < NUM_SRC; i++) e.fwd[i*2 +: 2] = m_fwd[i];
    e.ctl = 7'b0000000;

    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) m_fwd[i] = 2'd0;
      m_left  = 0;
      m_known = 1'b1;
    end else if (!mrdy) begin
      e.ctl = 7'b1111000;
    end else if (m_left > 0) begin
      e.ctl  = 7'b1110001;
      m_left = m_left - 1;
    end else if (br) begin
      e.ctl = 7'b0000110;
      for (int i = 0; i < NUM_SRC; i++) m_fwd[i] = 2'd0;
    end else begin
      hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        cm = (s[i] != 0) && rwc && (s[i] == rdc);
        mm = (s[i] != 0) && rwm && (s[i] == rdm);
        if (cm)      m_fwd[i] = memc ? 2'd2 : 2'd1;
        else if (mm) m_fwd[i] = 2'd2;
        else         m_fwd[i] = 2'd0;
        if (cm && memc) hit = 1'b1;
      end
      if (hit) m_left = LOAD_LAT;
    end

    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_fwd) begin
        n_total++;
        if (FwdSel === e.fwd) n_pass++;
        else $display("FAIL fwdsel t=%0t got=%h exp=%h", $time, FwdSel, e.fwd);
      end
      n_total++;
      if ({StallPC, StallIR, StallRC, StallCM, FlushIR, FlushRC, FlushCM} === e.ctl) n_pass++;
      else $display("FAIL stall_flush t=%0t got=%b exp=%b", $time,
                    {StallPC, StallIR, StallRC, StallCM, FlushIR, FlushRC, FlushCM}, e.ctl);
    end
  end

  initial begin
    reset = 1'b1; SrcAdr_R = '0; RdAdr_C = '0; RdAdr_M = '0;
    RegWrite_C = 1'b0; RegWrite_M = 1'b0; MemEn_C = 1'b0;
    BranchTaken_C = 1'b0; MemReady_M = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5, 5, 5, 5, 1, 1, 1, 1, 0);

    // independent instructions
    repeat (3) step(0, 3, 4, 7, 8, 1, 1, 0, 0, 1);
    // ALU chain
    step(0, 5, 0, 5, 0, 1, 0, 0, 0, 1);
    idle(1);
    // load-use on source 1
    step(0, 0, 6, 6, 0, 1, 0, 1, 0, 1);
    idle(5);
    // C beats M; register 0 never forwards
    step(0, 9, 9, 9, 9, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1, 1, 0, 1);
    step(0, 7, 0, 8, 7, 1, 1, 0, 0, 1);
    // both sources hit the load together
    step(0, 6, 6, 6, 0, 1, 0, 1, 0, 1);
    idle(5);
    // branch squashes a simultaneous load-use pattern
    step(0, 6, 0, 6, 0, 1, 0, 1, 1, 1);
    idle(2);
    // freeze in the middle of a load-use stall
    step(0, 6, 0, 6, 0, 1, 0, 1, 0, 1);
    idle(1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // reset on the second bubble of another stall
    step(0, 0, 6, 6, 0, 1, 0, 1, 0, 1);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // reset while frozen
    step(0, 6, 0, 6, 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 2),
           ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3)),
           ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) >= 15));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
